hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage datapath. It sits beside the IF/ID/EX/MEM pipeline registers. It detects load-use hazards between the instruction in decode (FD) and a load in execute (DX), and inserts bubbles for a configurable number of cycles. It also squashes wrong-path instructions when the registered branch decision (XF stage) is taken, and keeps saturating performance counters for stall and flush cycles.

---
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for the 5-stage pipeline.
// Controls are Mealy outputs; state and the saturating perf counters are registered.
module hazard_ctrl #(
  parameter int unsigned LU_STALL = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       FD_RS,
  input  logic [4:0]       FD_RT,
  input  logic             FD_UseRT,
  input  logic [4:0]       DX_RD,
  input  logic             DX_MemtoReg,
  input  logic             DX_RegWrite,
  input  logic             XF_BranchTaken,
  output logic             PC_Stall,
  output logic             FD_Stall,
  output logic             DX_Bubble,
  output logic             FD_Flush,
  output logic             PC_SelBranch,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  localparam logic [2:0]       StallInit = 3'(LU_STALL - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;

  assign lu = DX_MemtoReg & DX_RegWrite & (DX_RD != 5'd0) &
              ((DX_RD == FD_RS) | (FD_UseRT & (DX_RD == FD_RT)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PC_Stall     = 1'b0;
    FD_Stall     = 1'b0;
    DX_Bubble    = 1'b0;
    FD_Flush     = 1'b0;
    PC_SelBranch = 1'b0;
    Busy         = 1'b0;
    // Controls are forced low for the whole time reset is held.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (XF_BranchTaken) begin
            FD_Flush     = 1'b1;
            DX_Bubble    = 1'b1;
            PC_SelBranch = 1'b1;
          end else if (lu) begin
            PC_Stall  = 1'b1;
            FD_Stall  = 1'b1;
            DX_Bubble = 1'b1;
            if (LU_STALL > 1) begin
              state_d = StStall;
              cnt_d   = StallInit;
            end
          end
        end
        StStall: begin
          Busy = 1'b1;
          if (XF_BranchTaken) begin
            FD_Flush     = 1'b1;
            DX_Bubble    = 1'b1;
            PC_SelBranch = 1'b1;
            state_d      = StIdle;
            cnt_d        = 3'd0;
          end else begin
            PC_Stall  = 1'b1;
            FD_Stall  = 1'b1;
            DX_Bubble = 1'b1;
            cnt_d     = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (PC_Stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CntOne;
    if (FD_Flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CntOne;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations driven in parallel, each checked against
// a remaining-stall-cycles model of the hazard rules.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] fd_rs, fd_rt, dx_rd;
  logic       fd_usert, dx_mtr, dx_rw, br;

  logic [2:0]  pc_stall, fd_stall, dx_bubble, fd_flush, pc_sel, busy;
  logic [15:0] stall_cnt [3];
  logic [15:0] flush_cnt [3];
  logic [3:0]  sc_sat, fc_sat;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: per instance, forced stall cycles still owed after the current one.
  int lu_len  [3] = '{1, 3, 1};
  int cnt_max [3] = '{65535, 65535, 15};
  int rem     [3];
  int scnt    [3];
  int fcnt    [3];

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_STALL(1), .CNT_W(16)) u_def (
    .clk(clk), .rst(rst), .FD_RS(fd_rs), .FD_RT(fd_rt), .FD_UseRT(fd_usert), .DX_RD(dx_rd),
    .DX_MemtoReg(dx_mtr), .DX_RegWrite(dx_rw), .XF_BranchTaken(br),
    .PC_Stall(pc_stall[0]), .FD_Stall(fd_stall[0]), .DX_Bubble(dx_bubble[0]),
    .FD_Flush(fd_flush[0]), .PC_SelBranch(pc_sel[0]), .Busy(busy[0]),
    .StallCnt(stall_cnt[0]), .FlushCnt(flush_cnt[0])
  );

  hazard_ctrl #(.LU_STALL(3), .CNT_W(16)) u_l3 (
    .clk(clk), .rst(rst), .FD_RS(fd_rs), .FD_RT(fd_rt), .FD_UseRT(fd_usert), .DX_RD(dx_rd),
    .DX_MemtoReg(dx_mtr), .DX_RegWrite(dx_rw), .XF_BranchTaken(br),
    .PC_Stall(pc_stall[1]), .FD_Stall(fd_stall[1]), .DX_Bubble(dx_bubble[1]),
    .FD_Flush(fd_flush[1]), .PC_SelBranch(pc_sel[1]), .Busy(busy[1]),
    .StallCnt(stall_cnt[1]), .FlushCnt(flush_cnt[1])
  );

  hazard_ctrl #(.LU_STALL(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .FD_RS(fd_rs), .FD_RT(fd_rt), .FD_UseRT(fd_usert), .DX_RD(dx_rd),
    .DX_MemtoReg(dx_mtr), .DX_RegWrite(dx_rw), .XF_BranchTaken(br),
    .PC_Stall(pc_stall[2]), .FD_Stall(fd_stall[2]), .DX_Bubble(dx_bubble[2]),
    .FD_Flush(fd_flush[2]), .PC_SelBranch(pc_sel[2]), .Busy(busy[2]),
    .StallCnt(sc_sat), .FlushCnt(fc_sat)
  );

  assign stall_cnt[2] = {12'd0, sc_sat};
  assign flush_cnt[2] = {12'd0, fc_sat};

  task automatic chk(input string tag, input int i, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[u%0d]: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  function automatic bit hazard();
    return dx_mtr && dx_rw && (dx_rd != 0) &&
           ((dx_rd == fd_rs) || (fd_usert && (dx_rd == fd_rt)));
  endfunction

  // Expected {stall, flush, busy} for instance i given current inputs.
  task automatic expect_ctl(input int i, output bit st, output bit fl, output bit bz);
    st = 0; fl = 0; bz = 0;
    if (!rst) begin
      bz = rem[i] > 0;
      if (br) fl = 1;
      else if (rem[i] > 0 || hazard()) st = 1;
    end
  endtask

  task automatic check_all();
    bit st, fl, bz;
    for (int i = 0; i < 3; i++) begin
      expect_ctl(i, st, fl, bz);
      chk("PC_Stall", i, 16'(pc_stall[i]), 16'(st));
      chk("FD_Stall", i, 16'(fd_stall[i]), 16'(st));
      chk("DX_Bubble", i, 16'(dx_bubble[i]), 16'(st | fl));
      chk("FD_Flush", i, 16'(fd_flush[i]), 16'(fl));
      chk("PC_SelBranch", i, 16'(pc_sel[i]), 16'(fl));
      chk("Busy", i, 16'(busy[i]), 16'(bz));
      chk("StallCnt", i, stall_cnt[i], 16'(scnt[i]));
      chk("FlushCnt", i, flush_cnt[i], 16'(fcnt[i]));
      chk("StallFlushOverlap", i, 16'(fd_stall[i] & fd_flush[i]), 16'd0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
    end
  endtask

  task automatic model_step();
    bit st, fl, bz;
    for (int i = 0; i < 3; i++) begin
      expect_ctl(i, st, fl, bz);
      if (st && scnt[i] < cnt_max[i]) scnt[i]++;
      if (fl && fcnt[i] < cnt_max[i]) fcnt[i]++;
      if (fl) rem[i] = 0;
      else if (rem[i] > 0) rem[i]--;
      else if (st) rem[i] = lu_len[i] - 1;
    end
  endtask

  task automatic set_in(input int rs, input int rt, input bit usert, input int rd,
                        input bit mtr, input bit rw, input bit b);
    fd_rs = 5'(rs); fd_rt = 5'(rt); fd_usert = usert; dx_rd = 5'(rd);
    dx_mtr = mtr; dx_rw = rw; br = b;
  endtask

  // Inputs change on negedge; check mid-low phase; model advances on posedge.
  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Default load-use, rd=8 rs=8.
    set_in(8, 0, 0, 8, 1, 1, 0);
    tick();
    chk("LuDefCnt", 0, stall_cnt[0], 16'd1);
    chk("LuDefBusy", 0, 16'(busy[0]), 16'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Non-hazards and the rt hazard.
    set_in(0, 0, 1, 0, 1, 1, 0);
    tick();
    set_in(3, 9, 0, 9, 1, 1, 0);
    tick();
    set_in(3, 9, 1, 9, 1, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Reset asserted asynchronously during the 2nd stall cycle of the 3-cycle instance.
    set_in(8, 0, 0, 8, 1, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2;
    check_all();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("MidRstStall", 1, 16'(pc_stall[1]), 16'd0);
    chk("MidRstCnt", 1, stall_cnt[1], 16'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("PostRstStall", 1, 16'(pc_stall[1]), 16'd0);

    // Branch pre-empts a stall.
    set_in(8, 0, 0, 8, 1, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("BrPreStall", 1, stall_cnt[1], 16'd1);
    chk("BrPreFlush", 1, flush_cnt[1], 16'd1);
    chk("BrPreBusy", 1, 16'(busy[1]), 16'd0);

    // Hazard and branch together in idle.
    set_in(5, 0, 0, 5, 1, 1, 1);
    #2;
    chk("SimulStall", 1, 16'(pc_stall[1]), 16'd0);
    chk("SimulFlush", 1, 16'(fd_flush[1]), 16'd1);
    tick();
    chk("SimulScnt", 1, stall_cnt[1], 16'd1);
    chk("SimulFcnt", 1, flush_cnt[1], 16'd2);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Saturation of the 4-bit counter.
    set_in(7, 0, 0, 7, 1, 1, 0);
    repeat (20) tick();
    chk("SatStall", 2, stall_cnt[2], 16'd15);
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
